// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one external memory port between two bus masters (master 0: core
// fetch/load/store, master 1: DMA/debug). The granted command is registered
// onto the memory port and held until the memory answers with mem_ready. Read
// data and a one-cycle ready pulse then go back to the owning master. When
// both masters request together, the one that did not win last time goes
// first.
//
// Optional feature macro: MEM_ARB_TIMEOUT_EN
//   Defined    : an access that sees no mem_ready for TIMEOUT_CYCLES busy cycles
//                is aborted and reported with mN_err=1, mN_rdata=32'hFFFFFFFF.
//   Undefined  : no counter, a busy access waits indefinitely, mN_err stays 0.
//
// Ports
//   clk, reset           clock; synchronous active-low reset
//   mN_addr/wdata/width  master N command (N = 0, 1)
//   mN_read_en/write_en  master N request strobes (both set means write)
//   mN_ready/rdata/err   master N completion pulse, read data, abort flag
//   mem_addr/dout/width  registered memory command
//   mem_read_en/write_en registered memory strobes
//   mem_din, mem_ready   memory read data and access-complete handshake
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic        m0_read_en,
    input  logic        m0_write_en,
    input  logic [1:0]  m0_width,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic        m1_read_en,
    input  logic        m1_write_en,
    input  logic [1:0]  m1_width,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dout,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [1:0]  mem_width,
    input  logic [31:0] mem_din,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    // Reject a timeout limit that the counter cannot represent.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TIMEOUT_W)) begin : g_bad_timeout
        $error("mem_bus_arbiter: TIMEOUT_CYCLES must fit in TIMEOUT_W bits");
    end

    state_t      state, state_next;
    logic        last_grant, last_grant_next;
    logic [31:0] mem_addr_next, mem_dout_next;
    logic        mem_read_en_next, mem_write_en_next;
    logic [1:0]  mem_width_next;
    logic        m0_ready_next, m1_ready_next, m0_err_next, m1_err_next;
    logic [31:0] m0_rdata_next, m1_rdata_next;

    logic        req0, req1, pick1;
    logic        sel_read, sel_write;
    logic        done, rsp_err;
    logic [31:0] rsp_data;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);
    logic [TIMEOUT_W-1:0] busy_cnt, busy_cnt_next, busy_cnt_inc;
    assign busy_cnt_inc = busy_cnt + 1'b1;
`endif

    assign req0 = m0_read_en | m0_write_en;
    assign req1 = m1_read_en | m1_write_en;

    // Master 1 wins when it is alone, or on a tie when master 0 had the last grant.
    assign pick1     = req1 & (~req0 | ~last_grant);
    assign sel_read  = pick1 ? m1_read_en  : m0_read_en;
    assign sel_write = pick1 ? m1_write_en : m0_write_en;

    always_comb begin
        // NOTE: every signal driven here gets a default first; a path that
        // skipped one would infer a latch.
        state_next        = state;
        last_grant_next   = last_grant;
        mem_addr_next     = mem_addr;
        mem_dout_next     = mem_dout;
        mem_width_next    = mem_width;
        mem_read_en_next  = mem_read_en;
        mem_write_en_next = mem_write_en;
        m0_ready_next     = 1'b0;
        m1_ready_next     = 1'b0;
        m0_err_next       = 1'b0;
        m1_err_next       = 1'b0;
        m0_rdata_next     = m0_rdata;
        m1_rdata_next     = m1_rdata;
        done              = 1'b0;
        rsp_data          = '0;
        rsp_err           = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        busy_cnt_next     = busy_cnt;
`endif

        case (state)
            IDLE: begin
                // mem_ready is deliberately ignored while idle.
                if (req0 | req1) begin
                    state_next        = pick1 ? BUSY1 : BUSY0;
                    last_grant_next   = pick1;
                    mem_addr_next     = pick1 ? m1_addr  : m0_addr;
                    mem_dout_next     = pick1 ? m1_wdata : m0_wdata;
                    mem_width_next    = pick1 ? m1_width : m0_width;
                    // Both enables set means a write.
                    mem_write_en_next = sel_write;
                    mem_read_en_next  = sel_read & ~sel_write;
`ifdef MEM_ARB_TIMEOUT_EN
                    busy_cnt_next     = '0;
`endif
                end
            end

            BUSY0, BUSY1: begin
                // A mem_ready in the same cycle as the timeout limit completes normally.
                if (mem_ready) begin
                    done     = 1'b1;
                    rsp_data = mem_write_en ? '0 : mem_din;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (busy_cnt_inc == TIMEOUT_LIMIT) begin
                    done     = 1'b1;
                    rsp_data = '1;
                    rsp_err  = 1'b1;
                end else begin
                    busy_cnt_next = busy_cnt_inc;
                end
`endif
                if (done) begin
                    state_next        = IDLE;
                    mem_read_en_next  = 1'b0;
                    mem_write_en_next = 1'b0;
                    if (state == BUSY1) begin
                        m1_ready_next = 1'b1;
                        m1_rdata_next = rsp_data;
                        m1_err_next   = rsp_err;
                    end else begin
                        m0_ready_next = 1'b1;
                        m0_rdata_next = rsp_data;
                        m0_err_next   = rsp_err;
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    // The reset clears every output register (including the read-data holding
    // registers) and drops any access in flight without a ready pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            mem_addr     <= '0;
            mem_dout     <= '0;
            mem_width    <= '0;
            mem_read_en  <= 1'b0;
            mem_write_en <= 1'b0;
            m0_ready     <= 1'b0;
            m1_ready     <= 1'b0;
            m0_err       <= 1'b0;
            m1_err       <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            busy_cnt     <= '0;
`endif
        end else begin
            state        <= state_next;
            last_grant   <= last_grant_next;
            mem_addr     <= mem_addr_next;
            mem_dout     <= mem_dout_next;
            mem_width    <= mem_width_next;
            mem_read_en  <= mem_read_en_next;
            mem_write_en <= mem_write_en_next;
            m0_ready     <= m0_ready_next;
            m1_ready     <= m1_ready_next;
            m0_err       <= m0_err_next;
            m1_err       <= m1_err_next;
            m0_rdata     <= m0_rdata_next;
            m1_rdata     <= m1_rdata_next;
`ifdef MEM_ARB_TIMEOUT_EN
            busy_cnt     <= busy_cnt_next;
`endif
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Self-checking bench for mem_bus_arbiter: a table of single transactions,
// hand-written multi-cycle sequences (round-robin, reset in busy, timeout or
// indefinite wait depending on MEM_ARB_TIMEOUT_EN) and a randomized run
// compared against a transaction-rule reference model.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_read_en, m0_write_en, m1_read_en, m1_write_en;
    logic [1:0]  m0_width, m1_width;
    logic        m0_ready, m1_ready, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_addr, mem_dout, mem_din;
    logic        mem_read_en, mem_write_en, mem_ready;
    logic [1:0]  mem_width;

    mem_bus_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_read_en   (m0_read_en),
        .m0_write_en  (m0_write_en),
        .m0_width     (m0_width),
        .m0_ready     (m0_ready),
        .m0_rdata     (m0_rdata),
        .m0_err       (m0_err),
        .m1_addr      (m1_addr),
        .m1_wdata     (m1_wdata),
        .m1_read_en   (m1_read_en),
        .m1_write_en  (m1_write_en),
        .m1_width     (m1_width),
        .m1_ready     (m1_ready),
        .m1_rdata     (m1_rdata),
        .m1_err       (m1_err),
        .mem_addr     (mem_addr),
        .mem_dout     (mem_dout),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .mem_width    (mem_width),
        .mem_din      (mem_din),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, 32'(act), 32'(exp));
    endtask

    // Outputs are sampled 1 ns after the active edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ready_of(input int m);
        return (m == 0) ? m0_ready : m1_ready;
    endfunction

    function automatic logic [31:0] rdata_of(input int m);
        return (m == 0) ? m0_rdata : m1_rdata;
    endfunction

    function automatic logic err_of(input int m);
        return (m == 0) ? m0_err : m1_err;
    endfunction

    task automatic drive_master(input int m, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] width);
        if (m == 0) begin
            m0_read_en = rd; m0_write_en = wr; m0_addr = addr; m0_wdata = wdata; m0_width = width;
        end else begin
            m1_read_en = rd; m1_write_en = wr; m1_addr = addr; m1_wdata = wdata; m1_width = width;
        end
    endtask

    task automatic drop_master(input int m);
        drive_master(m, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_bit({tag, " m0_ready"}, m0_ready, 1'b0);
        check_bit({tag, " m1_ready"}, m1_ready, 1'b0);
        check_bit({tag, " m0_err"}, m0_err, 1'b0);
        check_bit({tag, " m1_err"}, m1_err, 1'b0);
        check({tag, " m0_rdata"}, m0_rdata, 32'h0);
        check({tag, " m1_rdata"}, m1_rdata, 32'h0);
        check({tag, " mem_addr"}, mem_addr, 32'h0);
        check({tag, " mem_dout"}, mem_dout, 32'h0);
        check({tag, " mem_width"}, 32'(mem_width), 32'h0);
        check_bit({tag, " mem_read_en"}, mem_read_en, 1'b0);
        check_bit({tag, " mem_write_en"}, mem_write_en, 1'b0);
    endtask

    // One full transaction for master `who`, whose request is already driven.
    // Grant, `lat` waiting cycles, then mem_ready with read data `din`.
    task automatic serve(input int who, input logic [31:0] exp_addr, input int lat,
                         input logic [31:0] din, input string tag);
        tick();
        check({tag, " grant addr"}, mem_addr, exp_addr);
        repeat (lat) tick();
        mem_ready = 1'b1;
        mem_din   = din;
        tick();
        check_bit({tag, " ready"}, ready_of(who), 1'b1);
        check_bit({tag, " other ready"}, ready_of(1 - who), 1'b0);
        check({tag, " rdata"}, rdata_of(who), din);
        mem_ready = 1'b0;
        drop_master(who);
    endtask

    typedef struct packed {
        logic        master;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  width;
        logic [3:0]  lat;
        logic [31:0] din;
        logic        exp_rd;
        logic        exp_wr;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [0:5];
    vec_t v;
    int   m, held, bad;

    // Reference model state: owner is -1 when no access is in flight.
    int          mdl_owner, mdl_last, busy_len, g, kind;
    logic        mdl_ready [2];
    logic [31:0] mdl_rdata [2];
    logic        mdl_rd, mdl_wr;
    logic [31:0] mdl_addr, mdl_dout;
    logic [1:0]  mdl_width;
    bit          p_active [2];
    logic        p_rd [2], p_wr [2];
    logic [31:0] p_addr [2], p_wdata [2];
    logic [1:0]  p_width [2];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        //                master rd    wr    addr           wdata          w     lat   din            exp_rd exp_wr exp_rdata
        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 2'd2, 4'd2, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, 2'd1, 4'd3, 32'hAAAA_5555, 1'b0, 1'b1, 32'h0000_0000};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 2'd2, 4'd0, 32'h1111_2222, 1'b0, 1'b1, 32'h0000_0000};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h0000_0003, 32'h0BAD_0BAD, 2'd0, 4'd0, 32'h0000_00A5, 1'b1, 1'b0, 32'h0000_00A5};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000, 2'd2, 4'd1, 32'h8765_4321, 1'b0, 1'b1, 32'h0000_0000};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_7FFE, 32'h5555_AAAA, 2'd1, 4'd5, 32'h0000_BEEF, 1'b1, 1'b0, 32'h0000_BEEF};

        reset = 1'b0;
        mem_ready = 1'b0;
        mem_din = 32'h0;
        drop_master(0);
        drop_master(1);
        tick();
        reset = 1'b1;
        check_all_zero("reset");

        // Table of single transactions.
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            m = int'(v.master);
            drive_master(m, v.rd, v.wr, v.addr, v.wdata, v.width);
            tick();
            check($sformatf("vec%0d mem_addr", i), mem_addr, v.addr);
            check($sformatf("vec%0d mem_dout", i), mem_dout, v.wdata);
            check($sformatf("vec%0d mem_width", i), 32'(mem_width), 32'(v.width));
            check_bit($sformatf("vec%0d mem_read_en", i), mem_read_en, v.exp_rd);
            check_bit($sformatf("vec%0d mem_write_en", i), mem_write_en, v.exp_wr);
            held = 0;
            for (int c = 0; c < int'(v.lat); c++) begin
                tick();
                if (mem_addr !== v.addr || mem_read_en !== v.exp_rd ||
                    mem_write_en !== v.exp_wr || m0_ready !== 1'b0 || m1_ready !== 1'b0)
                    held++;
            end
            check($sformatf("vec%0d held while busy", i), 32'(held), 32'h0);
            mem_ready = 1'b1;
            mem_din   = v.din;
            tick();
            check_bit($sformatf("vec%0d ready", i), ready_of(m), 1'b1);
            check_bit($sformatf("vec%0d other ready", i), ready_of(1 - m), 1'b0);
            check($sformatf("vec%0d rdata", i), rdata_of(m), v.exp_rdata);
            check_bit($sformatf("vec%0d err", i), err_of(m), 1'b0);
            check_bit($sformatf("vec%0d strobes dropped", i), mem_read_en | mem_write_en, 1'b0);
            drop_master(m);
            mem_ready = 1'b0;
            mem_din   = $urandom;
            tick();
            check_bit($sformatf("vec%0d ready pulse ends", i), ready_of(m), 1'b0);
            check($sformatf("vec%0d rdata holds", i), rdata_of(m), v.exp_rdata);
        end

        // mem_ready while idle must not produce a completion.
        mem_ready = 1'b1;
        tick();
        tick();
        check_bit("idle mem_ready m0", m0_ready, 1'b0);
        check_bit("idle mem_ready m1", m1_ready, 1'b0);
        mem_ready = 1'b0;

        // Round-robin: both request together each round; m1 won the last tie-free
        // grant above, so m0 goes first every round.
        for (int r = 0; r < 8; r++) begin
            drive_master(0, 1'b1, 1'b0, 32'h1000 + 32'(r), 32'h0, 2'd2);
            drive_master(1, 1'b1, 1'b0, 32'h2000 + 32'(r), 32'h0, 2'd2);
            serve(0, 32'h1000 + 32'(r), r % 3, 32'hA000_0000 + 32'(r), $sformatf("rr%0d m0", r));
            serve(1, 32'h2000 + 32'(r), (r + 1) % 3, 32'hB000_0000 + 32'(r), $sformatf("rr%0d m1", r));
        end

        // Reset in the second busy cycle, with mem_ready asserted at that edge.
        drive_master(0, 1'b1, 1'b0, 32'h0000_0500, 32'h0, 2'd2);
        tick();
        tick();
        reset = 1'b0;
        mem_ready = 1'b1;
        mem_din = 32'h0000_0055;
        tick();
        check_all_zero("reset in busy");
        reset = 1'b1;
        mem_ready = 1'b0;
        drive_master(1, 1'b1, 1'b0, 32'h0000_0600, 32'h0, 2'd2);
        serve(0, 32'h0000_0500, 1, 32'h0000_5A5A, "post-reset m0");
        serve(1, 32'h0000_0600, 0, 32'h0000_A5A5, "post-reset m1");

        // Memory that never answers.
        drive_master(0, 1'b1, 1'b0, 32'h0000_0900, 32'h0, 2'd2);
        tick();
        check_bit("stall strobe", mem_read_en, 1'b1);
`ifdef MEM_ARB_TIMEOUT_EN
        bad = 0;
        for (int c = 1; c < 255; c++) begin
            tick();
            if (mem_read_en !== 1'b1 || m0_ready !== 1'b0) bad++;
        end
        check("timeout busy for 255 cycles", 32'(bad), 32'h0);
        tick();
        check_bit("timeout ready", m0_ready, 1'b1);
        check_bit("timeout err", m0_err, 1'b1);
        check("timeout rdata", m0_rdata, 32'hFFFF_FFFF);
        check_bit("timeout strobe dropped", mem_read_en, 1'b0);
        drop_master(0);
        tick();
        check_bit("timeout ready pulse ends", m0_ready, 1'b0);
        check_bit("timeout err pulse ends", m0_err, 1'b0);
        // mem_ready in the 255th busy cycle completes normally.
        drive_master(0, 1'b1, 1'b0, 32'h0000_0904, 32'h0, 2'd2);
        tick();
        repeat (254) tick();
        mem_ready = 1'b1;
        mem_din = 32'h0BAD_F00D;
        tick();
        check_bit("limit ready", m0_ready, 1'b1);
        check_bit("limit err", m0_err, 1'b0);
        check("limit rdata", m0_rdata, 32'h0BAD_F00D);
        mem_ready = 1'b0;
        drop_master(0);
        tick();
`else
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            tick();
            if (mem_read_en !== 1'b1 || m0_ready !== 1'b0 || m1_ready !== 1'b0) bad++;
        end
        check("no-timeout stays busy", 32'(bad), 32'h0);
        check_bit("no-timeout err", m0_err, 1'b0);
        mem_ready = 1'b1;
        mem_din = 32'h1357_9BDF;
        tick();
        check_bit("late ready", m0_ready, 1'b1);
        check("late rdata", m0_rdata, 32'h1357_9BDF);
        mem_ready = 1'b0;
        drop_master(0);
        tick();
`endif

        // Randomized run against the reference model.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        mdl_owner = -1;
        mdl_last  = 1;
        busy_len  = 0;
        mdl_rd = 1'b0;
        mdl_wr = 1'b0;
        mdl_addr = 32'h0;
        mdl_dout = 32'h0;
        mdl_width = 2'd0;
        for (int k = 0; k < 2; k++) begin
            mdl_ready[k] = 1'b0;
            mdl_rdata[k] = 32'h0;
            p_active[k]  = 1'b0;
        end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            check_bit($sformatf("rnd c%0d m0_ready", cyc), m0_ready, mdl_ready[0]);
            check_bit($sformatf("rnd c%0d m1_ready", cyc), m1_ready, mdl_ready[1]);
            check($sformatf("rnd c%0d m0_rdata", cyc), m0_rdata, mdl_rdata[0]);
            check($sformatf("rnd c%0d m1_rdata", cyc), m1_rdata, mdl_rdata[1]);
            check_bit($sformatf("rnd c%0d mem_read_en", cyc), mem_read_en, mdl_rd);
            check_bit($sformatf("rnd c%0d mem_write_en", cyc), mem_write_en, mdl_wr);
            check_bit($sformatf("rnd c%0d err", cyc), m0_err | m1_err, 1'b0);
            if (mdl_rd || mdl_wr) begin
                check($sformatf("rnd c%0d mem_addr", cyc), mem_addr, mdl_addr);
                check($sformatf("rnd c%0d mem_dout", cyc), mem_dout, mdl_dout);
                check($sformatf("rnd c%0d mem_width", cyc), 32'(mem_width), 32'(mdl_width));
            end

            // Masters: a completed request retires; an idle master may start a new one.
            for (int k = 0; k < 2; k++) begin
                if (mdl_ready[k]) p_active[k] = 1'b0;
                if (!p_active[k] && $urandom_range(0, 2) == 0) begin
                    kind        = int'($urandom_range(0, 2));
                    p_rd[k]     = (kind != 1);
                    p_wr[k]     = (kind != 0);
                    p_addr[k]   = $urandom;
                    p_wdata[k]  = $urandom;
                    p_width[k]  = 2'($urandom_range(0, 2));
                    p_active[k] = 1'b1;
                end
                if (p_active[k])
                    drive_master(k, p_rd[k], p_wr[k], p_addr[k], p_wdata[k], p_width[k]);
                else
                    drive_master(k, 1'b0, 1'b0, $urandom, $urandom, 2'($urandom_range(0, 3)));
            end

            // Memory: random latency up to 6 extra cycles; stray mem_ready when idle.
            if (mdl_owner >= 0) begin
                busy_len++;
                mem_ready = (busy_len >= 6) || ($urandom_range(0, 2) == 0);
            end else begin
                mem_ready = ($urandom_range(0, 3) == 0);
            end
            mem_din = $urandom;

            // Expected result of the coming edge.
            mdl_ready[0] = 1'b0;
            mdl_ready[1] = 1'b0;
            if (mdl_owner < 0) begin
                if (p_active[0] && p_active[1]) g = 1 - mdl_last;
                else if (p_active[0])           g = 0;
                else if (p_active[1])           g = 1;
                else                            g = -1;
                if (g >= 0) begin
                    mdl_owner = g;
                    mdl_last  = g;
                    busy_len  = 0;
                    mdl_addr  = p_addr[g];
                    mdl_dout  = p_wdata[g];
                    mdl_width = p_width[g];
                    mdl_wr    = p_wr[g];
                    mdl_rd    = p_rd[g] && !p_wr[g];
                end
            end else if (mem_ready) begin
                mdl_ready[mdl_owner] = 1'b1;
                mdl_rdata[mdl_owner] = mdl_wr ? 32'h0 : mem_din;
                mdl_rd    = 1'b0;
                mdl_wr    = 1'b0;
                mdl_owner = -1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
